alu_mdu: RTL and testbench

- Parametrised successor to the single-cycle execute ALU.
- Performs the base ALU operations plus the RV32M multiply/divide group. The multiply/divide group runs on an iterative multi-cycle datapath.
- Operands arrive and results leave through valid/ready handshakes, so the pipeline stalls the EX stage while a multiply or divide is busy.
- Sits in EX, after operand select (PC/rs1, rs2/imm/4 muxing is done upstream).

---
 rtl/alu_mdu.sv | 192 +++++++++++++++++++
 tb/tb_alu_mdu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative RV32M multiply/divide behind valid/ready handshakes.
// Optional macro ALU_MDU_FAST_MUL_EN selects a single-cycle multiplier; divides stay iterative.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_md,
  input  logic [3:0]      alu_ctl,
  input  logic [2:0]      md_funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [SHW:0] LAST = (SHW+1)'(XLEN-1);

  state_t          state, state_nx;
  logic            accept, single, last;
  logic            is_div, div_zero, div_ovf;
  logic [XLEN-1:0] min_int;
  logic [XLEN-1:0] q_res;
  logic            q_less;
  logic            sa, sb, an, bn;
  logic [XLEN-1:0] mag_a, mag_b;

  // iterative datapath: acc/lo form the product pair or remainder/quotient pair
  logic [XLEN:0]   acc, acc_nx;
  logic [XLEN-1:0] lo, lo_nx, opnd, fin;
  logic            md_div, sel_hi, neg;
  logic [SHW:0]    cnt;
  logic [XLEN:0]   rs, sum;
  logic            ge;
  logic [2*XLEN-1:0] prod;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (state == BUSY) && (cnt == LAST);

  assign min_int  = {1'b1, {(XLEN-1){1'b0}}};
  assign is_div   = op_md && md_funct3[2];
  assign div_zero = (b == '0);
  assign div_ovf  = !md_funct3[0] && (a == min_int) && (b == '1);

`ifdef ALU_MDU_FAST_MUL_EN
  logic                   is_mul;
  logic signed [2*XLEN-1:0] fa, fb, fprod;
  assign is_mul = op_md && !md_funct3[2];
  assign fa     = {{XLEN{(md_funct3 != 3'b011) && a[XLEN-1]}}, a};
  assign fb     = {{XLEN{!md_funct3[1] && b[XLEN-1]}}, b};
  assign fprod  = fa * fb;
  assign single = !op_md || is_mul || (is_div && (div_zero || div_ovf));
`else
  assign single = !op_md || (is_div && (div_zero || div_ovf));
`endif

  // Single-cycle results: base ops, divide special cases, fast multiply
  always_comb begin
    q_res  = '0;
    q_less = 1'b0;
    if (!op_md) begin
      case (alu_ctl)
        4'b0000: q_res = a + b;
        4'b1000: q_res = a - b;
        4'b0001: q_res = a << b[SHW-1:0];
        4'b0010: begin q_less = ($signed(a) < $signed(b)); q_res = XLEN'(q_less); end
        4'b1010: begin q_less = (a < b); q_res = XLEN'(q_less); end
        4'b0100: q_res = a ^ b;
        4'b0101: q_res = a >> b[SHW-1:0];
        4'b1101: q_res = $unsigned($signed(a) >>> b[SHW-1:0]);
        4'b0110: q_res = a | b;
        4'b0111: q_res = a & b;
        4'b0011: q_res = b;
        default: q_res = '0;
      endcase
    end else if (is_div) begin
      if (div_zero) q_res = md_funct3[1] ? a : '1;
      else          q_res = md_funct3[1] ? '0 : a;
    end
`ifdef ALU_MDU_FAST_MUL_EN
    else begin
      q_res = (md_funct3 == 3'b000) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
`endif
  end

  always_comb begin
    sa    = md_funct3[2] ? !md_funct3[0] : (md_funct3 != 3'b011);
    sb    = md_funct3[2] ? !md_funct3[0] : !md_funct3[1];
    an    = sa && a[XLEN-1];
    bn    = sb && b[XLEN-1];
    mag_a = an ? -a : a;
    mag_b = bn ? -b : b;
  end

  always_comb begin
    acc_nx = acc;
    lo_nx  = lo;
    rs     = '0;
    sum    = '0;
    ge     = 1'b0;
    prod   = '0;
    fin    = '0;
    if (md_div) begin
      rs     = {acc[XLEN-1:0], lo[XLEN-1]};
      ge     = (rs >= {1'b0, opnd});
      acc_nx = ge ? rs - {1'b0, opnd} : rs;
      lo_nx  = {lo[XLEN-2:0], ge};
      fin    = sel_hi ? acc_nx[XLEN-1:0] : lo_nx;
      if (neg) fin = -fin;
    end else begin
      sum    = acc + (lo[0] ? {1'b0, opnd} : '0);
      acc_nx = {1'b0, sum[XLEN:1]};
      lo_nx  = {sum[0], lo[XLEN-1:1]};
      prod   = {acc_nx[XLEN-1:0], lo_nx};
      if (neg) prod = -prod;
      fin    = sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = single ? DONE : BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE: begin
        if (accept)         state_nx = single ? DONE : BUSY;
        else if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b1;
      less   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      lo     <= '0;
      opnd   <= '0;
      md_div <= 1'b0;
      sel_hi <= 1'b0;
      neg    <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (single) begin
        result <= q_res;
        zero   <= (q_res == '0);
        less   <= q_less;
      end else begin
        acc    <= '0;
        lo     <= mag_a;
        opnd   <= mag_b;
        md_div <= md_funct3[2];
        sel_hi <= md_funct3[2] ? md_funct3[1] : (md_funct3 != 3'b000);
        neg    <= (md_funct3[2] && md_funct3[1]) ? an : (an ^ bn);
      end
    end else if (state == BUSY) begin
      acc <= acc_nx;
      lo  <= lo_nx;
      if (last) begin
        result <= fin;
        zero   <= (fin == '0);
        less   <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized self-checking bench for alu_mdu against a plain-arithmetic reference model.
module tb_alu_mdu;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, op_md, flush, out_valid, out_ready, zero, less;
  logic [3:0]      alu_ctl;
  logic [2:0]      md_funct3;
  logic [XLEN-1:0] a, b, result;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_md(op_md),
    .alu_ctl(alu_ctl), .md_funct3(md_funct3), .a(a), .b(b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .less(less)
  );

  always #5 clk = ~clk;

`ifdef ALU_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_model(input logic md, input logic [3:0] ctl, input logic [2:0] f3,
                                    input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic lt, output int lat);
    longint          sx, sy, q;
    logic [63:0]     p;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    r   = 0;
    lt  = 0;
    lat = 1;
    if (!md) begin
      case (ctl)
        4'b0000: r = x + y;
        4'b1000: r = x - y;
        4'b0001: r = x << y[4:0];
        4'b0010: begin lt = (sx < sy); r = {31'b0, lt}; end
        4'b1010: begin lt = (x < y);   r = {31'b0, lt}; end
        4'b0100: r = x ^ y;
        4'b0101: r = x >> y[4:0];
        4'b1101: r = 32'(sx >>> y[4:0]);
        4'b0110: r = x | y;
        4'b0111: r = x & y;
        4'b0011: r = y;
        default: r = 0;
      endcase
    end else if (!f3[2]) begin
      lat = MUL_LAT;
      case (f3[1:0])
        2'b00, 2'b01: p = 64'(sx * sy);
        2'b10:        p = 64'(sx * longint'({32'b0, y}));
        default:      p = {32'b0, x} * {32'b0, y};
      endcase
      r = (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
    end else if (y == 0) begin
      r = f3[1] ? x : 32'hFFFF_FFFF;
    end else if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      r = f3[1] ? 32'h0 : x;
    end else begin
      lat = XLEN + 1;
      case (f3[1:0])
        2'b00:   q = sx / sy;
        2'b01:   q = longint'(x) / longint'(y);
        2'b10:   q = sx % sy;
        default: q = longint'(x) % longint'(y);
      endcase
      r = q[31:0];
    end
  endfunction

  task automatic drive(input logic md, input logic [3:0] ctl, input logic [2:0] f3,
                       input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1; op_md = md; alu_ctl = ctl; md_funct3 = f3; a = x; b = y;
  endtask

  task automatic scramble();
    in_valid = 1'b0; op_md = 1'($urandom); alu_ctl = 4'($urandom);
    md_funct3 = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Issue one op from idle, wait for its result, compare against the model.
  task automatic run_op(input string tag, input logic md, input logic [3:0] ctl, input logic [2:0] f3,
                        input logic [31:0] x, input logic [31:0] y, output logic [31:0] got);
    logic [31:0] er;
    logic        el;
    int          elat, lat;
    ref_model(md, ctl, f3, x, y, er, el, elat);
    @(negedge clk);
    drive(md, ctl, f3, x, y);
    #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 scramble();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_result"}, result, er);
    check({tag, "_zero"}, 32'(zero), 32'(er == 0));
    check({tag, "_less"}, 32'(less), 32'(el));
    got = result;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 16));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    int          seen;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    scramble();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_result", result, 32'h0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_less", 32'(less), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD then SUB back-to-back: SUB accepted in ADD's DONE cycle
    drive(1'b0, 4'b0000, 3'b000, 32'h7FFF_FFFF, 32'h1);
    @(posedge clk);
    #1 drive(1'b0, 4'b1000, 3'b000, 32'd5, 32'd5);
    @(negedge clk);
    check("b2b_add_valid", 32'(out_valid), 32'd1);
    check("b2b_add_result", result, 32'h8000_0000);
    check("b2b_add_zero", 32'(zero), 32'd0);
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 scramble();
    @(negedge clk);
    check("b2b_sub_valid", 32'(out_valid), 32'd1);
    check("b2b_sub_result", result, 32'h0);
    check("b2b_sub_zero", 32'(zero), 32'd1);

    run_op("slt", 1'b0, 4'b0010, 3'b0, 32'hFFFF_FFFF, 32'h1, r);
    check("slt_const", r, 32'h1);
    run_op("sltu", 1'b0, 4'b1010, 3'b0, 32'hFFFF_FFFF, 32'h1, r);
    check("sltu_const", r, 32'h0);
    run_op("sra", 1'b0, 4'b1101, 3'b0, 32'h8000_0000, 32'h24, r);
    check("sra_const", r, 32'hF800_0000);
    run_op("mulh", 1'b1, 4'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, r);
    check("mulh_const", r, 32'h4000_0000);
    run_op("mul", 1'b1, 4'b0, 3'b000, 32'h8000_0000, 32'h8000_0000, r);
    check("mul_const", r, 32'h0);
    run_op("mulhsu", 1'b1, 4'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r);
    check("mulhsu_const", r, 32'hFFFF_FFFF);
    run_op("div", 1'b1, 4'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, r);
    check("div_const", r, 32'hFFFF_FFFD);
    run_op("rem", 1'b1, 4'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, r);
    check("rem_const", r, 32'hFFFF_FFFF);
    run_op("divu0", 1'b1, 4'b0, 3'b101, 32'd7, 32'd0, r);
    check("divu0_const", r, 32'hFFFF_FFFF);
    run_op("remu0", 1'b1, 4'b0, 3'b111, 32'd7, 32'd0, r);
    check("remu0_const", r, 32'd7);
    run_op("divovf", 1'b1, 4'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r);
    check("divovf_const", r, 32'h8000_0000);
    run_op("removf", 1'b1, 4'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r);
    check("removf_const", r, 32'h0);

    // Backpressure, then release together with a new request
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b0, 4'b0000, 3'b0, 32'd10, 32'd20);
    @(posedge clk);
    #1 scramble();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", result, 32'd30);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    drive(1'b0, 4'b0100, 3'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    #1 check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 scramble();
    @(negedge clk);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_result", result, 32'hFF00_FF00);

    // Flush on cycle 10 of a DIVU
    @(negedge clk);
    drive(1'b1, 4'b0, 3'b101, 32'd1000, 32'd3);
    @(posedge clk);
    #1 scramble();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);

    // Reset on cycle 5 of a MUL
    run_op("pre_rst", 1'b0, 4'b0000, 3'b0, 32'd3, 32'd4, r);
    @(negedge clk);
    drive(1'b1, 4'b0, 3'b000, 32'd6, 32'd7);
    @(posedge clk);
    #1 scramble();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_result", result, 32'h0);
    check("mrst_zero", 32'(zero), 32'd1);
    check("mrst_less", 32'(less), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("mrst_no_valid", 32'(seen), 32'd0);
    run_op("post_rst_add", 1'b0, 4'b0000, 3'b0, 32'd100, 32'd23, r);

    for (int i = 0; i < 150; i++) begin
      run_op("rand", 1'($urandom), 4'($urandom), 3'($urandom), pick(), pick(), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
